// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - op encodings, default geometry and stage-register sizing for pipelined_cla_adder
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_BLOCK_W = 8;

  // valid + carry + operand A, operand B and partial sum, plus the two sign bits when flags are built
  function automatic int stage_reg_bits(input int width, input bit flags_en);
    return 3 * width + 2 + (flags_en ? 2 : 0);
  endfunction

endpackage

// File: rtl/cla_block.sv
// rtl/cla_block.sv - combinational BLOCK_W-bit lookahead slice with group propagate/generate
module cla_block #(
  parameter int BLOCK_W = 8
) (
  input  logic [BLOCK_W-1:0] a,
  input  logic [BLOCK_W-1:0] b,
  input  logic               cin,
  output logic [BLOCK_W-1:0] s,
  output logic               p,
  output logic               g
);

  logic [BLOCK_W-1:0] gen_bit;
  logic [BLOCK_W-1:0] prop_bit;
  logic [BLOCK_W-1:0] carry;

  always_comb begin
    gen_bit  = a & b;
    prop_bit = a ^ b;
    carry    = '0;
    carry[0] = cin;
    for (int i = 1; i < BLOCK_W; i++) begin
      carry[i] = gen_bit[i-1] | (prop_bit[i-1] & carry[i-1]);
    end
    // group generate is the block carry-out assuming a zero carry-in
    g = 1'b0;
    for (int i = 0; i < BLOCK_W; i++) begin
      g = gen_bit[i] | (prop_bit[i] & g);
    end
    p = &prop_bit;
    s = prop_bit ^ carry;
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead add/sub, one block per stage, valid/ready
// PIPE_ADDER_FLAGS_EN enables the registered overflow and zero flags.
module pipelined_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int BLOCK_W = DEFAULT_BLOCK_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             carry_in,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NUM_BLOCKS = WIDTH / BLOCK_W;
`ifdef PIPE_ADDER_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif
  localparam int STAGE_BITS = stage_reg_bits(WIDTH, FLAGS_EN);

  // operands shift down one block per stage; the sum fills in from the top
  typedef struct packed {
    logic             valid;
    logic             carry;
`ifdef PIPE_ADDER_FLAGS_EN
    logic             a_msb;
    logic             b_msb;
`endif
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } stage_t;

  if ((WIDTH % BLOCK_W) != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of BLOCK_W");
  end
  if ($bits(stage_t) != STAGE_BITS) begin : g_bad_stage
    $error("stage register layout out of step with stage_reg_bits");
  end

  stage_t             pipe  [NUM_BLOCKS];
  stage_t             nxt   [NUM_BLOCKS];
  stage_t             load;
  logic [BLOCK_W-1:0] blk_s [NUM_BLOCKS];
  logic               blk_p [NUM_BLOCKS];
  logic               blk_g [NUM_BLOCKS];
  logic               adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    load       = '0;
    load.valid = in_valid;
    load.a     = num1;
    load.b     = (op == OP_SUB) ? ~num2 : num2;
    load.carry = (op == OP_SUB) ? 1'b1 : carry_in;
`ifdef PIPE_ADDER_FLAGS_EN
    load.a_msb = num1[WIDTH-1];
    load.b_msb = load.b[WIDTH-1];
`endif
  end

  for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_stage
    cla_block #(
      .BLOCK_W(BLOCK_W)
    ) u_cla (
      .a  (pipe[k].a[BLOCK_W-1:0]),
      .b  (pipe[k].b[BLOCK_W-1:0]),
      .cin(pipe[k].carry),
      .s  (blk_s[k]),
      .p  (blk_p[k]),
      .g  (blk_g[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NUM_BLOCKS; k++) begin
      nxt[k]       = pipe[k];
      nxt[k].carry = blk_g[k] | (blk_p[k] & pipe[k].carry);
      nxt[k].a     = pipe[k].a >> BLOCK_W;
      nxt[k].b     = pipe[k].b >> BLOCK_W;
      nxt[k].sum   = (pipe[k].sum >> BLOCK_W) | (WIDTH'(blk_s[k]) << (WIDTH - BLOCK_W));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_BLOCKS; k++) begin
        pipe[k] <= '0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (adv) begin
      pipe[0] <= load;
      for (int k = 1; k < NUM_BLOCKS; k++) begin
        pipe[k] <= nxt[k-1];
      end
      out_valid <= nxt[NUM_BLOCKS-1].valid;
      sum       <= nxt[NUM_BLOCKS-1].sum;
      carry_out <= nxt[NUM_BLOCKS-1].carry;
    end
  end

`ifdef PIPE_ADDER_FLAGS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (adv) begin
      overflow <= (pipe[NUM_BLOCKS-1].a_msb == pipe[NUM_BLOCKS-1].b_msb) &&
                  (nxt[NUM_BLOCKS-1].sum[WIDTH-1] != pipe[NUM_BLOCKS-1].a_msb);
      zero     <= ~|nxt[NUM_BLOCKS-1].sum;
    end
  end
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - directed self-checking bench for pipelined_cla_adder (32/8 and 16/4)
module tb_pipelined_cla_adder;

`ifdef PIPE_ADDER_FLAGS_EN
  localparam logic FLG = 1'b1;
`else
  localparam logic FLG = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] num1;
  logic [31:0] num2;
  logic        carry_in;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  logic        n16_in_valid;
  logic        n16_in_ready;
  logic [15:0] n16_num1;
  logic [15:0] n16_num2;
  logic        n16_carry_in;
  logic        n16_op;
  logic        n16_out_valid;
  logic        n16_out_ready;
  logic [15:0] n16_sum;
  logic        n16_carry_out;
  logic        n16_overflow;
  logic        n16_zero;

  int errors = 0;
  int checks = 0;

  pipelined_cla_adder dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .num1     (num1),
    .num2     (num2),
    .carry_in (carry_in),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry_out(carry_out),
    .overflow (overflow),
    .zero     (zero)
  );

  pipelined_cla_adder #(.WIDTH(16), .BLOCK_W(4)) dut16 (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (n16_in_valid),
    .in_ready (n16_in_ready),
    .num1     (n16_num1),
    .num2     (n16_num2),
    .carry_in (n16_carry_in),
    .op       (n16_op),
    .out_valid(n16_out_valid),
    .out_ready(n16_out_ready),
    .sum      (n16_sum),
    .carry_out(n16_carry_out),
    .overflow (n16_overflow),
    .zero     (n16_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic o, input logic [31:0] es,
                        input logic eco, input logic eov, input logic ez);
    num1      = a;
    num2      = b;
    carry_in  = ci;
    op        = o;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, " in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check({tag, " early valid"}, out_valid, 0);
    tick();
    check({tag, " valid"}, out_valid, 1);
    check({tag, " sum"}, sum, es);
    check({tag, " carry_out"}, carry_out, eco);
    check({tag, " overflow"}, overflow, eov);
    check({tag, " zero"}, zero, ez);
    tick();
  endtask

  logic [31:0] va  [8];
  logic [31:0] vb  [8];
  logic [31:0] vs  [8];
  logic        vc  [8];
  logic        vo  [8];
  logic        vco [8];
  logic        vov [8];
  logic        vz  [8];

  initial begin
    int issued;
    int rcv;
    int stray;

    reset_n       = 1'b0;
    in_valid      = 1'b0;
    num1          = '0;
    num2          = '0;
    carry_in      = 1'b0;
    op            = 1'b0;
    out_ready     = 1'b1;
    n16_in_valid  = 1'b0;
    n16_num1      = '0;
    n16_num2      = '0;
    n16_carry_in  = 1'b0;
    n16_op        = 1'b0;
    n16_out_ready = 1'b1;

    #1;
    check("reset out_valid", out_valid, 0);
    check("reset sum", sum, 0);
    check("reset carry_out", carry_out, 0);
    check("reset overflow", overflow, 0);
    check("reset zero", zero, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    check("release in_ready", in_ready, 1);

    run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, FLG, 1'b0);
    run_op("sub_eq", 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, FLG);
    run_op("sub_borrow", 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("add_ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, FLG);
    run_op("sub_ign_cin", 32'h0000_0010, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_000F, 1'b1, 1'b0, 1'b0);
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, FLG, 1'b0);

    // back-to-back issue with a three-cycle consumer stall
    va[0] = 32'h0000_0001; vb[0] = 32'h0000_0002; vc[0] = 0; vo[0] = 0; vs[0] = 32'h0000_0003; vco[0] = 0; vov[0] = 0;   vz[0] = 0;
    va[1] = 32'h0000_00FF; vb[1] = 32'h0000_0001; vc[1] = 0; vo[1] = 0; vs[1] = 32'h0000_0100; vco[1] = 0; vov[1] = 0;   vz[1] = 0;
    va[2] = 32'h0000_0010; vb[2] = 32'h0000_0001; vc[2] = 0; vo[2] = 1; vs[2] = 32'h0000_000F; vco[2] = 1; vov[2] = 0;   vz[2] = 0;
    va[3] = 32'h8000_0000; vb[3] = 32'h8000_0000; vc[3] = 0; vo[3] = 0; vs[3] = 32'h0000_0000; vco[3] = 1; vov[3] = FLG; vz[3] = FLG;
    va[4] = 32'h1234_5678; vb[4] = 32'h1111_1111; vc[4] = 1; vo[4] = 0; vs[4] = 32'h2345_678A; vco[4] = 0; vov[4] = 0;   vz[4] = 0;
    va[5] = 32'h0000_0000; vb[5] = 32'h0000_0001; vc[5] = 0; vo[5] = 1; vs[5] = 32'hFFFF_FFFF; vco[5] = 0; vov[5] = 0;   vz[5] = 0;
    va[6] = 32'hFFFF_0000; vb[6] = 32'h0000_FFFF; vc[6] = 0; vo[6] = 0; vs[6] = 32'hFFFF_FFFF; vco[6] = 0; vov[6] = 0;   vz[6] = 0;
    va[7] = 32'h7FFF_FFFF; vb[7] = 32'hFFFF_FFFF; vc[7] = 0; vo[7] = 1; vs[7] = 32'h8000_0000; vco[7] = 0; vov[7] = FLG; vz[7] = 0;

    issued = 0;
    rcv    = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 5 && c <= 7);
      if (issued < 8) begin
        in_valid = 1'b1;
        num1     = va[issued];
        num2     = vb[issued];
        carry_in = vc[issued];
        op       = vo[issued];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 5 && c <= 7) begin
        check("stall in_ready", in_ready, 0);
        check("stall out_valid", out_valid, 1);
        check("stall sum hold", sum, vs[0]);
        check("stall carry hold", carry_out, vco[0]);
      end
      if (c == 4 || c == 8) check("flow in_ready", in_ready, 1);
      if (out_valid && out_ready) begin
        if (rcv < 8) begin
          check($sformatf("stream%0d sum", rcv), sum, vs[rcv]);
          check($sformatf("stream%0d carry_out", rcv), carry_out, vco[rcv]);
          check($sformatf("stream%0d overflow", rcv), overflow, vov[rcv]);
          check($sformatf("stream%0d zero", rcv), zero, vz[rcv]);
        end else begin
          check("stream extra result", out_valid, 0);
        end
        rcv++;
      end
      if (in_valid && in_ready) issued++;
      tick();
    end
    check("stream issued", issued, 8);
    check("stream received", rcv, 8);

    // reset while three operations are in flight
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      num1     = 32'hFFFF_FFFF;
      num2     = 32'h0000_0002 + c;
      carry_in = 1'b0;
      op       = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("pre-reset out_valid", out_valid, 1);
    check("pre-reset sum", sum, 32'h0000_0001);
    reset_n = 1'b0;
    #1;
    check("mid reset out_valid", out_valid, 0);
    check("mid reset sum", sum, 0);
    check("mid reset carry_out", carry_out, 0);
    check("mid reset overflow", overflow, 0);
    check("mid reset zero", zero, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    check("post reset in_ready", in_ready, 1);
    stray = 0;
    repeat (8) begin
      tick();
      if (out_valid) stray++;
    end
    check("post reset stale results", stray, 0);

    // 16-bit, 4-bit-block instance
    n16_num1     = 16'h8000;
    n16_num2     = 16'h8000;
    n16_carry_in = 1'b0;
    n16_op       = 1'b0;
    n16_in_valid = 1'b1;
    #1;
    check("w16 in_ready", n16_in_ready, 1);
    tick();
    n16_in_valid = 1'b0;
    repeat (3) tick();
    check("w16 early valid", n16_out_valid, 0);
    tick();
    check("w16 valid", n16_out_valid, 1);
    check("w16 sum", n16_sum, 16'h0000);
    check("w16 carry_out", n16_carry_out, 1);
    check("w16 overflow", n16_overflow, FLG);
    check("w16 zero", n16_zero, FLG);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
